dmem_responder: RTL

- Data-memory responder serving the MEM stage's load/store requests.
- Returns load data, sign- or zero-extended and lane-aligned, which feeds the writeback read-data input.
- Single outstanding request over a valid/ready request channel, with a fixed-latency, one-cycle response pulse.
- Holds the word-addressed data RAM internally.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/dmem_load_align.sv | 40 ++++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: XLEN, memory funct3 codes,
// data-memory responder states and the access-size check.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_funct3_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_e;

   // 1 when the offset breaks natural alignment or funct3 is unknown
   function automatic logic mem_misalign(
      input logic [1:0] off,
      input logic [2:0] funct3
   );
      logic bad;
      bad = 1'b1;
      case (funct3)
         MEM_B, MEM_BU: bad = 1'b0;
         MEM_H, MEM_HU: bad = off[0];
         MEM_W:         bad = |off;
         default:       bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane extraction and sign/zero extension,
// plus the alignment / funct3 legality flag.
import riscv_pkg::*;

module dmem_load_align #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] res,
   output logic            misalign
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v   = 8'(word >> {off, 3'b000});
   assign half_v   = 16'(word >> {off[1], 4'b0000});
   assign misalign = mem_misalign(off, funct3);

   always_comb begin
      res = '0;
      unique case (1'b1)
         (funct3 == MEM_B):
            res = {{(XLEN-8){byte_v[7]}}, byte_v};
         (funct3 == MEM_BU):
            res = {{(XLEN-8){1'b0}}, byte_v};
         (funct3 == MEM_H):
            res = {{(XLEN-16){half_v[15]}}, half_v};
         (funct3 == MEM_HU):
            res = {{(XLEN-16){1'b0}}, half_v};
         (funct3 == MEM_W):
            res = word;
         default:
            res = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store,
// fixed-latency single-cycle response, internal word RAM.
import riscv_pkg::*;

module dmem_responder #(
   parameter int XLEN        = riscv_pkg::XLEN,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [2:0]      req_funct3,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   dmem_state_e     state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            we_q;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] word_q;

   logic            accept;
   logic            st_ok;
   logic [AW-1:0]   idx;
   logic [NB-1:0]   be;
   logic [XLEN-1:0] wrep;
   logic [XLEN-1:0] ld_res;
   logic            ld_mis;
   logic            unused_addr;

   assign idx         = req_addr[AW+1:2];
   assign unused_addr = ^req_addr[XLEN-1:AW+2];
   assign accept      = req_valid && req_ready;

   // stores have no unsigned forms, so funct3[2] is illegal for them
   assign st_ok = accept && req_we && !req_funct3[2]
                  && !mem_misalign(req_addr[1:0], req_funct3);

   always_comb begin
      be   = '0;
      wrep = req_wdata;
      unique case (1'b1)
         (req_funct3[1:0] == 2'b00): begin
            be   = NB'(1) << req_addr[1:0];
            wrep = {NB{req_wdata[7:0]}};
         end
         (req_funct3[1:0] == 2'b01): begin
            be   = NB'(3) << {req_addr[1], 1'b0};
            wrep = {(NB/2){req_wdata[15:0]}};
         end
         (req_funct3[1:0] == 2'b10): begin
            be   = '1;
         end
         default: begin
            be   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (st_ok) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[idx][i*8 +: 8] <= wrep[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         off_q   <= '0;
         f3_q    <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q   <= req_we;
            off_q  <= req_addr[1:0];
            f3_q   <= req_funct3;
            word_q <= mem[idx];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid && rst_n) begin
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   dmem_load_align #(
      .XLEN(XLEN)
   ) u_align (
      .word    (word_q),
      .off     (off_q),
      .funct3  (f3_q),
      .res     (ld_res),
      .misalign(ld_mis)
   );

   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid
                       && (ld_mis || (we_q && f3_q[2]));
   assign resp_rdata = (resp_valid && !resp_err && !we_q)
                       ? ld_res : '0;

endmodule
